coin_sense: RTL and testbench
=============================

# coin_sense

Front-end coin sensing stage for the soda vending machine, directly upstream of the vending FSM. Takes three raw, asynchronous, bouncing coin-chute sensor lines (nickel, dime, quarter) and synchronizes, debounces and edge-detects them. Queues accepted coins in a small FIFO and presents them to the vending FSM as single-cycle one-hot codes on `coin[2:0]`: 4 = nickel, 2 = dime, 1 = quarter, 0 = idle. Coins that cannot be queued are flagged on `reject` for the mechanical return flap.

## Interface
- `DEBOUNCE_CYCLES`, 4, consecutive synchronized cycles a level must hold before it is accepted; legal range ≥1.
- `FIFO_DEPTH`, 4, coin queue entries; power of two, ≥2.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `nickel_raw`  in  1  async chute sensor, high while coin passes.
- `dime_raw`  in  1  async chute sensor.
- `quarter_raw`  in  1  async chute sensor.
- `coin_inhibit`  in  1  synchronous; vending FSM busy (dispensing), hold coins in queue.
- `coin`  out  3  registered one-hot coin code to vending FSM, one cycle per coin.
- `reject`  out  1  registered one-cycle pulse, coin dropped (queue full or simultaneous coins).
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  current queue occupancy.

## Operation
- Reset: all sync flops, debounced levels, counters, event flags, FIFO pointers cleared; `coin`=0, `reject`=0, `fifo_level`=0.
- Per line: 2-flop synchronizer → debouncer. Debouncer holds `deb` and counter `cnt`. If sync ≠ `deb`, `cnt` increments. On the DEBOUNCE_CYCLES-th consecutive differing cycle, `deb` takes the sync value and `cnt` clears. If sync = `deb`, `cnt` clears. A bounce restarts the count.
- Event: registered flag, set for one cycle when `deb` rises 0→1. Falling edges generate nothing.
- Arbitration, per cycle:
  - Exactly one event → push code (4/2/1).
  - Two or three events in the same cycle → push nothing, pulse `reject` once.
- Push while full with no pop in that cycle → coin dropped, `reject` pulses. Push while full with a pop in the same cycle is accepted; level is unchanged.
- Pop: on each edge where FIFO is non-empty and `coin_inhibit`=0, `coin` ← head and the entry is popped. Otherwise `coin` ← 0. `coin` is never high for two cycles from one entry; back-to-back queued coins appear on consecutive cycles.
- `coin_inhibit` only stalls the pop; sensing and pushing continue.
- A line still high when `rst` deasserts counts as a new coin after normal latency (`deb` resets to 0).

## Timing
- Raw rising sampled at edge k, stable thereafter, FIFO empty, no inhibit:
  - sync2 = 1 after edge k+1.
  - `deb`/event set after edge k+1+DEBOUNCE_CYCLES.
  - FIFO write at edge k+2+DEBOUNCE_CYCLES.
  - `coin` high after edge k+3+DEBOUNCE_CYCLES, for exactly one cycle. Default: edge k+7.
- Minimum raw pulse guaranteed to register: DEBOUNCE_CYCLES+1 cycles. Shorter pulses may be ignored.
- `reject` asserts after the edge at which the failed push would have occurred, for one cycle per dropped event.
- `fifo_level` updates on the push/pop edge. Inhibit deasserting at edge j → first `coin` after edge j+1.
- Reset asserted mid-operation: outputs go to 0 immediately (async); queued coins are lost.

## Structure
- Shared package `soda_pkg`:
  - coin code constants `COIN_NICKEL`=3'b100, `COIN_DIME`=3'b010, `COIN_QUARTER`=3'b001, `COIN_NONE`=3'b000.
  - Used by this block and the vending FSM.
- Sub-module `coin_debounce`, instantiated three times: synchronizer + debounce counter + rise-event flag, parameterized by DEBOUNCE_CYCLES.
- FIFO, arbitration and output register are inline in `coin_sense`.

## Test plan
- Single nickel: `nickel_raw` high 8 cycles from edge 10 → `coin`=4 for exactly one cycle after edge 17; `reject` stays 0; `fifo_level` 0→1→0.
- Bounce: `dime_raw` toggles 1,0,1,0 per cycle, then holds high → a single `coin`=2, DEBOUNCE_CYCLES+3 edges after the final rise sample.
- Simultaneous: nickel and quarter rise on the same edge → `reject` one cycle; no `coin`; `fifo_level` stays 0.
- Inhibit and queue: hold `coin_inhibit`=1 and insert 5 separated quarters → `fifo_level` reaches 4, 5th coin gives `reject`. Release inhibit → `coin`=1 on 4 consecutive cycles.
- Full with pop: FIFO full, inhibit released on the same edge a new dime is pushed → accepted, no `reject`, level stays 4.
- Reset mid-debounce: assert `rst` while `cnt`=2 on nickel line → `coin`/`reject`/`fifo_level`=0. Release with line still high → one `coin`=4 after full latency.

Source files
------------

// File: rtl/soda_pkg.sv
// Shared definitions for the soda vending machine: coin codes seen by the
// vending FSM and a small helper used by the coin front end.
package soda_pkg;

  typedef logic [2:0] coin_t;

  localparam coin_t COIN_NICKEL  = 3'b100;
  localparam coin_t COIN_DIME    = 3'b010;
  localparam coin_t COIN_QUARTER = 3'b001;
  localparam coin_t COIN_NONE    = 3'b000;

  // Number of rise events flagged in one cycle (0..3).
  function automatic logic [1:0] count_events(input logic [2:0] ev);
    return {1'b0, ev[0]} + {1'b0, ev[1]} + {1'b0, ev[2]};
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-chute line: two-flop synchronizer, consecutive-cycle debouncer and
// a registered single-cycle flag on each accepted 0->1 transition.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Synchronizer, debounce counter and rise flag next-state.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    rise_d = deb_d & ~deb_q;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/coin_sense.sv
// Coin front end: debounces the three chute sensors, queues accepted coins and
// hands them to the vending FSM one per cycle as one-hot codes.
module coin_sense
  import soda_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                nickel_raw,
  input  logic                                dime_raw,
  input  logic                                quarter_raw,
  input  logic                                coin_inhibit,
  output logic [2:0]                          coin,
  output logic                                reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [2:0]    ev_s;
  logic [1:0]    n_ev_s;
  logic          pop_s, push_s, full_s;

  coin_t         mem_q [FIFO_DEPTH];
  coin_t         mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  coin_t         coin_q, coin_d;
  logic          reject_q, reject_d;

  // Event bit order matches the one-hot coin code, so a lone event is its own code.
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
    .clk(clk), .rst(rst), .raw(nickel_raw), .rise(ev_s[2])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .clk(clk), .rst(rst), .raw(dime_raw), .rise(ev_s[1])
  );
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_quarter (
    .clk(clk), .rst(rst), .raw(quarter_raw), .rise(ev_s[0])
  );

  // Arbitration, queue bookkeeping and output selection.
  always_comb begin
    n_ev_s   = count_events(ev_s);
    full_s   = (level_q == LW'(FIFO_DEPTH));
    pop_s    = (level_q != {LW{1'b0}}) && !coin_inhibit;
    push_s   = (n_ev_s == 2'd1) && (!full_s || pop_s);
    reject_d = (n_ev_s >= 2'd2) || ((n_ev_s == 2'd1) && full_s && !pop_s);
    mem_d    = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = ev_s;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      coin_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      coin_d   = COIN_NONE;
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Queue storage, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= COIN_NONE;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  assign coin       = coin_q;
  assign reject     = reject_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_coin_sense.sv
// Bench for coin_sense: table of single-insertion vectors plus hand-written
// sequences for timing, bounce, queueing, full-with-pop and reset corners.
module tb_coin_sense;
  import soda_pkg::*;

  logic       clk;
  logic       rst;
  logic       nickel_raw, dime_raw, quarter_raw, coin_inhibit;
  logic [2:0] coin;
  logic       reject;
  logic [2:0] fifo_level;

  int    checks = 0;
  int    errors = 0;
  int    rej_seen = 0;
  int    base;
  coin_t exp_q[$];

  typedef struct {
    string      name;
    logic [2:0] raw;
    int         hold;
    logic [2:0] exp_coin;
    int         exp_rej;
  } vec_t;

  vec_t vecs[8];

  coin_sense #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .nickel_raw(nickel_raw), .dime_raw(dime_raw), .quarter_raw(quarter_raw),
    .coin_inhibit(coin_inhibit),
    .coin(coin), .reject(reject), .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_coin(input logic [2:0] m);
    {nickel_raw, dime_raw, quarter_raw} = m;
    tick(6);
    {nickel_raw, dime_raw, quarter_raw} = 3'b000;
    tick(12);
  endtask

  // Scoreboard: every coin the DUT emits must match the next expected code.
  always @(negedge clk) begin
    if (!rst) begin
      if (reject) rej_seen++;
      if (coin != COIN_NONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_coin", {29'd0, coin}, 32'd0);
        end else begin
          check("scoreboard_coin", {29'd0, coin}, {29'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    vecs[0] = '{"nickel",        3'b100, 8, COIN_NICKEL,  0};
    vecs[1] = '{"dime",          3'b010, 8, COIN_DIME,    0};
    vecs[2] = '{"quarter",       3'b001, 8, COIN_QUARTER, 0};
    vecs[3] = '{"nick_quar",     3'b101, 8, COIN_NONE,    1};
    vecs[4] = '{"nick_dime",     3'b110, 8, COIN_NONE,    1};
    vecs[5] = '{"all_three",     3'b111, 8, COIN_NONE,    1};
    vecs[6] = '{"short_pulse",   3'b010, 2, COIN_NONE,    0};
    vecs[7] = '{"min_pulse",     3'b001, 5, COIN_QUARTER, 0};

    rst = 1'b1;
    {nickel_raw, dime_raw, quarter_raw} = 3'b000;
    coin_inhibit = 1'b0;
    tick(2);
    check("reset_coin",   {29'd0, coin}, 32'd0);
    check("reset_reject", {31'd0, reject}, 32'd0);
    check("reset_level",  {29'd0, fifo_level}, 32'd0);
    rst = 1'b0;
    tick(3);

    // Exact latency of a single nickel.
    base = rej_seen;
    nickel_raw = 1'b1;
    exp_q.push_back(COIN_NICKEL);
    tick(7);
    check("nickel_early_coin", {29'd0, coin}, 32'd0);
    check("nickel_level_1",    {29'd0, fifo_level}, 32'd1);
    tick(1);
    check("nickel_coin",       {29'd0, coin}, {29'd0, COIN_NICKEL});
    check("nickel_level_0",    {29'd0, fifo_level}, 32'd0);
    nickel_raw = 1'b0;
    tick(1);
    check("nickel_one_cycle",  {29'd0, coin}, 32'd0);
    tick(12);
    check("nickel_no_reject",  rej_seen - base, 32'd0);

    // Table of single insertions.
    for (int v = 0; v < 8; v++) begin
      base = rej_seen;
      if (vecs[v].exp_coin != COIN_NONE) exp_q.push_back(vecs[v].exp_coin);
      {nickel_raw, dime_raw, quarter_raw} = vecs[v].raw;
      tick(vecs[v].hold);
      {nickel_raw, dime_raw, quarter_raw} = 3'b000;
      tick(16);
      check({vecs[v].name, "_coin_seen"}, exp_q.size(), 32'd0);
      check({vecs[v].name, "_reject"},    rej_seen - base, vecs[v].exp_rej);
      check({vecs[v].name, "_level"},     {29'd0, fifo_level}, 32'd0);
    end

    // Bouncing dime: only the final stable rise counts.
    dime_raw = 1'b1; tick(1);
    dime_raw = 1'b0; tick(1);
    dime_raw = 1'b1; tick(1);
    dime_raw = 1'b0; tick(1);
    dime_raw = 1'b1;
    exp_q.push_back(COIN_DIME);
    tick(7);
    check("bounce_early_coin", {29'd0, coin}, 32'd0);
    tick(1);
    check("bounce_coin",       {29'd0, coin}, {29'd0, COIN_DIME});
    tick(4);
    dime_raw = 1'b0;
    tick(12);
    check("bounce_single", exp_q.size(), 32'd0);

    // Inhibit, fill queue, overflow reject, then drain back-to-back.
    coin_inhibit = 1'b1;
    base = rej_seen;
    for (int i = 0; i < 4; i++) begin
      send_coin(COIN_QUARTER);
      exp_q.push_back(COIN_QUARTER);
    end
    send_coin(COIN_QUARTER);
    check("inh_level_full", {29'd0, fifo_level}, 32'd4);
    check("inh_overflow",   rej_seen - base, 32'd1);
    coin_inhibit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("drain_coin",  {29'd0, coin}, {29'd0, COIN_QUARTER});
      check("drain_level", {29'd0, fifo_level}, 3 - i);
    end
    tick(1);
    check("drain_done", {29'd0, coin}, 32'd0);
    tick(4);

    // Full queue: push and pop on the same edge.
    coin_inhibit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_coin(COIN_QUARTER);
      exp_q.push_back(COIN_QUARTER);
    end
    check("fp_level_full", {29'd0, fifo_level}, 32'd4);
    base = rej_seen;
    dime_raw = 1'b1;
    exp_q.push_back(COIN_DIME);
    tick(6);
    dime_raw = 1'b0;
    coin_inhibit = 1'b0;
    tick(1);
    check("fp_level_kept", {29'd0, fifo_level}, 32'd4);
    check("fp_first_coin", {29'd0, coin}, {29'd0, COIN_QUARTER});
    tick(3);
    check("fp_last_quarter", {29'd0, coin}, {29'd0, COIN_QUARTER});
    tick(1);
    check("fp_dime_out", {29'd0, coin}, {29'd0, COIN_DIME});
    check("fp_no_reject", rej_seen - base, 32'd0);
    tick(4);

    // Reset while nickel line is mid-debounce with coins queued.
    coin_inhibit = 1'b1;
    send_coin(COIN_QUARTER);
    send_coin(COIN_QUARTER);
    nickel_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("rst_coin",   {29'd0, coin}, 32'd0);
    check("rst_reject", {31'd0, reject}, 32'd0);
    check("rst_level",  {29'd0, fifo_level}, 32'd0);
    coin_inhibit = 1'b0;
    tick(2);
    rst = 1'b0;
    exp_q.push_back(COIN_NICKEL);
    tick(7);
    check("post_rst_early", {29'd0, coin}, 32'd0);
    tick(1);
    check("post_rst_coin",  {29'd0, coin}, {29'd0, COIN_NICKEL});
    nickel_raw = 1'b0;
    tick(12);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
